mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the 8-bit MIPS core. It decodes the 6-bit opcode and sequences the datapath across fetch, decode, execute, memory and writeback. It drives every datapath mux select, including the 5-bit register-destination mux (reg_dst), the ALU operand selects and the PC-source select. It stalls on a memory ready handshake and flags illegal opcodes.

Parameters:
OP_W, 6, opcode width
STATE_W, 4, width of state debug output

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
run  input  1  leave IDLE and begin fetching; sampled only in IDLE
opcode  input  6  instruction opcode from IR[31:26]; valid from DECODE onward
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  writeback data select: 0=ALUOut, 1=MDR
reg_dst  output  1  5-bit write-address mux select: 0=rt, 1=rd
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 1, 10=sign-ext imm, 11=shifted imm
alu_op  output  2  00=add, 01=sub, 10=funct-decoded
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal_op  output  1  sticky; set on an unsupported opcode, cleared only by reset
state  output  STATE_W  current state encoding, for debug

Behaviour:
- Async reset: state=IDLE(0), illegal_op=0. In IDLE all control outputs are 0.
- Outputs are Moore decodes of the registered state. Exceptions: pc_write and ir_write in FETCH, and the write-completion pulse, are qualified by mem_ready.
- Encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=13. Encodings 14 and 15 go to IDLE on the next clock.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - mem_ready=0 -> stay in FETCH; ir_write=0, pc_write=0.
  - mem_ready=1 -> ir_write=1, pc_write=1 that cycle; go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Transition by opcode:
  - 000000 R-type -> EXECUTE
  - 100011 lw -> MEM_ADDR
  - 101011 sw -> MEM_ADDR
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDI_EX
  - 000010 j -> JUMP
  - any other -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE. Uses the opcode held since DECODE (IR is stable).
- MEM_READ: mem_read=1, i_or_d=1. Stay until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1, held until mem_ready. In the mem_ready=1 cycle instr_done=1 -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
- TRAP: illegal_op<=1, all enables 0 -> IDLE. run must be re-asserted to continue.
- Latency with mem_ready=1 throughout: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles, each FETCH to FETCH.
- Each memory wait cycle adds exactly one cycle. mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Reset asserted mid-instruction: immediate return to IDLE, all outputs 0 in the same cycle. No partial writes after reset deasserts.
- run is ignored outside IDLE; deasserting it does not stop an instruction in flight.

Test Plan:
- Reset then run=1, mem_ready=1, opcode=000000 -> states 1,2,7,8,1; reg_dst=1, reg_write=1 in state 8; instr_done pulses once.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> stays in state 4 for 3 extra cycles; mem_to_reg=1, reg_dst=0, reg_write=1 in MEM_WB; total 8 cycles.
- sw (101011), mem_ready=1 -> states 1,2,3,6,1; mem_write=1 and i_or_d=1 in state 6; reg_write never 1.
- beq (000100) then j (000010) -> beq: pc_write_cond=1, alu_op=01 in state 9. j: pc_write=1, pc_source=10 in state 10. Both return to FETCH after 3 cycles.
- opcode=111111 -> DECODE->TRAP->IDLE; illegal_op=1 and stays 1 through later run=1 instructions until reset.
- reset asserted in MEM_WRITE -> state=0, mem_write=0 immediately; FETCH stall with mem_ready=0 -> ir_write=0, pc_write=0 every stalled cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller owns the master side; the datapath and memory own the slave side.
interface mips_multicycle_ctrl_if #(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
);
   logic               run;
   logic [OP_W-1:0]    opcode;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               mem_to_reg;
   logic               reg_dst;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic               instr_done;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   modport master (
      input  run, opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, illegal_op, state
   );

   modport slave (
      output run, opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, illegal_op, state
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS core: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready and flags unsupported opcodes.
module mips_multicycle_ctrl #(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_MEM_ADDR  = 4'd3,
      ST_MEM_READ  = 4'd4,
      ST_MEM_WB    = 4'd5,
      ST_MEM_WRITE = 4'd6,
      ST_EXECUTE   = 4'd7,
      ST_ALU_WB    = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JUMP      = 4'd10,
      ST_ADDI_EX   = 4'd11,
      ST_ADDI_WB   = 4'd12,
      ST_TRAP      = 4'd13
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   state_t state_r;
   logic   illegal_r;

   // State sequencing and the sticky illegal-opcode flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         illegal_r <= 1'b0;
      end else begin
         if (state_r == ST_TRAP) begin
            illegal_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE:      state_r <= bus.run ? ST_FETCH : ST_IDLE;
            ST_FETCH:     state_r <= bus.mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
               case (bus.opcode)
                  OP_RTYPE: state_r <= ST_EXECUTE;
                  OP_LW:    state_r <= ST_MEM_ADDR;
                  OP_SW:    state_r <= ST_MEM_ADDR;
                  OP_BEQ:   state_r <= ST_BRANCH;
                  OP_ADDI:  state_r <= ST_ADDI_EX;
                  OP_J:     state_r <= ST_JUMP;
                  default:  state_r <= ST_TRAP;
               endcase
            end
            // IR is stable here, so the opcode still selects load vs store.
            ST_MEM_ADDR: begin
               case (bus.opcode)
                  OP_LW:   state_r <= ST_MEM_READ;
                  OP_SW:   state_r <= ST_MEM_WRITE;
                  default: state_r <= ST_TRAP;
               endcase
            end
            ST_MEM_READ:  state_r <= bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_r <= ST_FETCH;
            ST_MEM_WRITE: state_r <= bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXECUTE:   state_r <= ST_ALU_WB;
            ST_ALU_WB:    state_r <= ST_FETCH;
            ST_BRANCH:    state_r <= ST_FETCH;
            ST_JUMP:      state_r <= ST_FETCH;
            ST_ADDI_EX:   state_r <= ST_ADDI_WB;
            ST_ADDI_WB:   state_r <= ST_FETCH;
            ST_TRAP:      state_r <= ST_IDLE;
            default:      state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.state      = STATE_W'(state_r);
   assign bus.illegal_op = illegal_r;

   // Moore decode of the state; only the memory handshakes look at mem_ready.
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      bus.instr_done    = 1'b0;
      case (state_r)
         ST_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         ST_DECODE: begin
            bus.alu_src_b = 2'b11;
         end
         ST_MEM_ADDR, ST_ADDI_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         ST_MEM_READ: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            bus.instr_done = 1'b1;
         end
         ST_MEM_WRITE: begin
            bus.mem_write  = 1'b1;
            bus.i_or_d     = 1'b1;
            bus.instr_done = bus.mem_ready;
         end
         ST_EXECUTE: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
         end
         ST_ALU_WB: begin
            bus.reg_write  = 1'b1;
            bus.reg_dst    = 1'b1;
            bus.instr_done = 1'b1;
         end
         ST_ADDI_WB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
         end
         ST_BRANCH: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
            bus.instr_done    = 1'b1;
         end
         ST_JUMP: begin
            bus.pc_write   = 1'b1;
            bus.pc_source  = 2'b10;
            bus.instr_done = 1'b1;
         end
         default: begin
            bus.pc_write = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: expected state/control words are queued
// as each cycle's stimulus is driven and compared when sampled at the falling edge.
module tb_mips_multicycle_ctrl;

   localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                          S_MADDR = 4'd3, S_MREAD = 4'd4,  S_MWB = 4'd5,
                          S_MWRITE = 4'd6, S_EXEC = 4'd7,  S_ALUWB = 4'd8,
                          S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11,
                          S_ADDIWB = 4'd12, S_TRAP = 4'd13;

   // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
   //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done}
   localparam logic [16:0] E_ZERO      = 17'd0;
   localparam logic [16:0] E_FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_FETCH_STL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_MADDR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_MREAD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_MWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1};
   localparam logic [16:0] E_MWR_RDY   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};
   localparam logic [16:0] E_MWR_STL   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_EXEC      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
   localparam logic [16:0] E_ALUWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1};
   localparam logic [16:0] E_ADDIEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
   localparam logic [16:0] E_ADDIWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1};
   localparam logic [16:0] E_BRANCH    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1};
   localparam logic [16:0] E_JUMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1};

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                          OP_BAD = 6'b111111;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] ctl;
      logic        ill;
   } exp_t;

   logic   clk;
   logic   reset;
   exp_t   sb_q[$];
   int     checks;
   int     failures;
   int     step_n;

   mips_multicycle_ctrl_if #(.OP_W(6), .STATE_W(4)) bus ();

   mips_multicycle_ctrl #(.OP_W(6), .STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] actual_ctl();
      return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done};
   endfunction

   task automatic check_now();
      exp_t e;
      logic [16:0] act;
      e   = sb_q.pop_front();
      act = actual_ctl();
      step_n++;
      checks += 3;
      assert (bus.state === e.st) else begin
         failures++;
         $error("FAIL state step=%0d got=%0d want=%0d", step_n, bus.state, e.st);
      end
      assert (act === e.ctl) else begin
         failures++;
         $error("FAIL ctl step=%0d got=%b want=%b", step_n, act, e.ctl);
      end
      assert (bus.illegal_op === e.ill) else begin
         failures++;
         $error("FAIL illegal_op step=%0d got=%b want=%b", step_n, bus.illegal_op, e.ill);
      end
   endtask

   task automatic step(input logic r, input logic [5:0] op, input logic mr,
                       input logic [3:0] est, input logic [16:0] ectl, input logic eill);
      exp_t e;
      @(posedge clk);
      #1;
      bus.run       = r;
      bus.opcode    = op;
      bus.mem_ready = mr;
      e = {est, ectl, eill};
      sb_q.push_back(e);
      @(negedge clk);
      check_now();
   endtask

   initial begin
      exp_t e;
      checks        = 0;
      failures      = 0;
      step_n        = 0;
      reset         = 1'b1;
      bus.run       = 1'b0;
      bus.opcode    = OP_R;
      bus.mem_ready = 1'b0;
      e = {S_IDLE, E_ZERO, 1'b0};
      sb_q.push_back(e);
      @(negedge clk);
      check_now();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // R-type; run drops after launch and must not stop the instruction
      step(1'b1, OP_R, 1'b1, S_IDLE,   E_ZERO,      1'b0);
      step(1'b0, OP_R, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_R, 1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_R, 1'b1, S_EXEC,   E_EXEC,      1'b0);
      step(1'b0, OP_R, 1'b1, S_ALUWB,  E_ALUWB,     1'b0);
      // lw with three memory wait cycles
      step(1'b0, OP_LW, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_LW, 1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_LW, 1'b1, S_MADDR,  E_MADDR,     1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, OP_LW, 1'b0, S_MREAD, E_MREAD, 1'b0);
      end
      step(1'b0, OP_LW, 1'b1, S_MREAD,  E_MREAD,     1'b0);
      step(1'b0, OP_LW, 1'b1, S_MWB,    E_MWB,       1'b0);
      // sw
      step(1'b0, OP_SW, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_SW, 1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_SW, 1'b1, S_MADDR,  E_MADDR,     1'b0);
      step(1'b0, OP_SW, 1'b1, S_MWRITE, E_MWR_RDY,   1'b0);
      // beq then j
      step(1'b0, OP_BEQ, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_BEQ, 1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_BEQ, 1'b1, S_BRANCH, E_BRANCH,    1'b0);
      step(1'b0, OP_J,   1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_J,   1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_J,   1'b1, S_JUMP,   E_JUMP,      1'b0);
      // illegal opcode traps to IDLE and the flag sticks
      step(1'b0, OP_BAD, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_BAD, 1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_BAD, 1'b1, S_TRAP,   E_ZERO,      1'b0);
      step(1'b0, OP_R,   1'b1, S_IDLE,   E_ZERO,      1'b1);
      step(1'b1, OP_R,   1'b1, S_IDLE,   E_ZERO,      1'b1);
      step(1'b0, OP_R,   1'b1, S_FETCH,  E_FETCH_RDY, 1'b1);
      step(1'b0, OP_R,   1'b1, S_DECODE, E_DECODE,    1'b1);
      step(1'b0, OP_R,   1'b1, S_EXEC,   E_EXEC,      1'b1);
      step(1'b0, OP_R,   1'b1, S_ALUWB,  E_ALUWB,     1'b1);
      // fetch stall, then sw stalled in MEM_WRITE and interrupted by reset
      step(1'b0, OP_SW, 1'b0, S_FETCH,  E_FETCH_STL, 1'b1);
      step(1'b0, OP_SW, 1'b0, S_FETCH,  E_FETCH_STL, 1'b1);
      step(1'b0, OP_SW, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b1);
      step(1'b0, OP_SW, 1'b1, S_DECODE, E_DECODE,    1'b1);
      step(1'b0, OP_SW, 1'b1, S_MADDR,  E_MADDR,     1'b1);
      step(1'b0, OP_SW, 1'b0, S_MWRITE, E_MWR_STL,   1'b1);
      reset = 1'b1;
      e = {S_IDLE, E_ZERO, 1'b0};
      sb_q.push_back(e);
      #1;
      check_now();
      @(posedge clk);
      #1;
      reset = 1'b0;
      // recovery with addi
      step(1'b0, OP_ADDI, 1'b1, S_IDLE,   E_ZERO,      1'b0);
      step(1'b1, OP_ADDI, 1'b1, S_IDLE,   E_ZERO,      1'b0);
      step(1'b0, OP_ADDI, 1'b1, S_FETCH,  E_FETCH_RDY, 1'b0);
      step(1'b0, OP_ADDI, 1'b1, S_DECODE, E_DECODE,    1'b0);
      step(1'b0, OP_ADDI, 1'b1, S_ADDIEX, E_ADDIEX,    1'b0);
      step(1'b0, OP_ADDI, 1'b1, S_ADDIWB, E_ADDIWB,    1'b0);
      step(1'b0, OP_R,    1'b0, S_FETCH,  E_FETCH_STL, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
